// File: rtl/nibble_serial_add32_if.sv
// rtl/nibble_serial_add32_if.sv - start/busy/done operand and result bundle for the serial adder
// The requester drives operands and start; the adder returns status and the held result.
interface nibble_serial_add32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/nibble_serial_add32.sv
// rtl/nibble_serial_add32.sv - multi-cycle adder reusing one DIGIT-wide slice per clock
// Result digits shift into acc from the top so the final acc is the sum with no reordering.
module nibble_serial_add32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add32_if.slave    bus
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DIGIT:0]   digit_sum;
  logic             last_digit;

  assign digit_sum  = {1'b0, a_sh_q[DIGIT-1:0]}
                    + {1'b0, b_sh_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
  assign last_digit = (cnt_q == CNT_W'(NDIG - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (last_digit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end

  // Datapath next-state: operands only load in IDLE, so start during RUN is inert.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        acc_d   = {digit_sum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) begin
          sum_d  = acc_d;
          cout_d = digit_sum[DIGIT];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add32.sv
// tb/tb_nibble_serial_add32.sv - directed and random checks of the nibble-serial adder
module tb_nibble_serial_add32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  nibble_serial_add32_if #(.WIDTH(32)) bus ();

  nibble_serial_add32 #(.WIDTH(32), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation from accept to done; optionally pulses start mid-run with other operands.
  task automatic run_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic c_v,
                        input bit inject, input logic [31:0] exp_sum, input logic exp_cout);
    int          k;
    int          busy_n;
    bit          unstable;
    logic [31:0] prev_sum;
    logic        prev_cout;
    prev_sum  = bus.sum;
    prev_cout = bus.cout;
    bus.start = 1'b1;
    bus.a     = a_v;
    bus.b     = b_v;
    bus.cin   = c_v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.cin   = 1'($urandom_range(0, 1));
    check("busy_on_accept", {63'd0, bus.busy}, 64'd1);
    k        = 0;
    busy_n   = 0;
    unstable = 1'b0;
    while (!bus.done && k < 20) begin
      if (bus.busy) busy_n++;
      if (bus.sum !== prev_sum || bus.cout !== prev_cout) unstable = 1'b1;
      if (inject && (k == 2 || k == 6)) begin
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'h0000_0001;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    check("latency", 64'(k), 64'd8);
    check("busy_cycles", 64'(busy_n), 64'd8);
    check("no_partial", {63'd0, unstable}, 64'd0);
    check("busy_at_done", {63'd0, bus.busy}, 64'd0);
    check("sum", {32'd0, bus.sum}, {32'd0, exp_sum});
    check("cout", {63'd0, bus.cout}, {63'd0, exp_cout});
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, bus.done}, 64'd0);
    check("idle_after", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vc [3];
    logic [32:0] ve [3];
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] re;
    int          t, idx;
    bit          load_next;

    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_sum",  {32'd0, bus.sum},  64'd0);
    check("rst_cout", {63'd0, bus.cout}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0);
    check("inject_no_restart", {63'd0, bus.busy}, 64'd0);

    // Abort mid-run: outputs clear at once, without waiting for a clock edge.
    bus.start = 1'b1;
    bus.a     = 32'h0F0F_0F0F;
    bus.b     = 32'hF0F0_F0F0;
    bus.cin   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_sum",  {32'd0, bus.sum},  64'd0);
    check("abort_cout", {63'd0, bus.cout}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_done", {63'd0, bus.done}, 64'd0);
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0, 32'h0000_0000, 1'b1);

    // Back-to-back with start held high: each accept lands in the previous done cycle.
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0002; vc[0] = 1'b0; ve[0] = 33'h0_0000_0003;
    va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vc[1] = 1'b0; ve[1] = 33'h1_0000_0000;
    va[2] = 32'hDEAD_BEEF; vb[2] = 32'h1111_1111; vc[2] = 1'b1; ve[2] = 33'h0_EFBE_D001;
    bus.start = 1'b1;
    bus.a = va[0]; bus.b = vb[0]; bus.cin = vc[0];
    @(posedge clk); #1;
    bus.a = va[1]; bus.b = vb[1]; bus.cin = vc[1];
    t = 0;
    idx = 0;
    load_next = 1'b0;
    while (idx < 3 && t < 40) begin
      @(posedge clk); #1;
      t++;
      if (load_next) begin
        load_next = 1'b0;
        if (idx + 1 < 3) begin
          bus.a = va[idx+1]; bus.b = vb[idx+1]; bus.cin = vc[idx+1];
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.done) begin
        check("b2b_when", 64'(t), 64'(8 + 9 * idx));
        check("b2b_result", {31'd0, bus.cout, bus.sum}, {31'd0, ve[idx]});
        idx++;
        load_next = 1'b1;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", 64'(idx), 64'd3);
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      re = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      run_op(ra, rb, rc, 1'b0, re[31:0], re[32]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check("idle_hold", {31'd0, bus.cout, bus.sum}, {31'd0, re});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
